dmem_responder: RTL
===================

// Module: dmem_responder
// PURPOSE
// - Data-memory responder for the microcoded controller's MEMR/MEMW/LST/LU control fields.
// - Serves each load/store in exactly two cycles: the controller holds the request for 2 cycles (STY stay cycle + follow-up).
// - Performs byte-lane steering, byte enables, sign/zero extension and optional misalignment trapping.
// - Owns a byte-enabled synchronous SRAM sized by ADDR_W.
// PARAMETERS
// - ADDR_W  10  word-address bits; memory depth = 2**ADDR_W 32-bit words
// - INIT_Z  1   1: memory contents zeroed at elaboration; 0: left uninitialised
// PORTS
// - clk         in   1   clock, rising edge
// - rstn        in   1   asynchronous active-low reset
// - mem_read    in   1   load request (MEMR), held 2 cycles per load
// - mem_write   in   1   store request (MEMW), held 2 cycles per store
// - lst         in   2   access size: 00 byte, 01 half, 11 word, 10 reserved (treated as word)
// - lu          in   1   1 = zero-extend load, 0 = sign-extend load
// - addr        in   32  byte address (ALU result); bits [ADDR_W+1:2] index the memory, upper bits ignored
// - wdata       in   32  store data (rs2), right-aligned
// - load_data   out  32  extended load result; valid while mem_ready=1
// - mem_ready   out  1   high in the 2nd (ACCESS) cycle of every request
// - mem_err     out  1   error flag, qualified by mem_ready (see BEHAVIOUR and CONFIGURATION)
// BEHAVIOUR
// - Reset: state=IDLE; mem_ready=0, mem_err=0, load_data=0; latched address, type and read data cleared. SRAM contents untouched.
// - FSM states: IDLE and ACCESS.
// - IDLE, mem_read|mem_write=1:
//   - latch addr[1:0], lst, lu and the request kind;
//   - for a store, write the SRAM with the byte enables this edge;
//   - for a load, register the SRAM read word this edge;
//   - next state ACCESS.
// - IDLE, no request: remain in IDLE; no SRAM activity.
// - ACCESS:
//   - mem_ready=1; load_data = extend(lane-select(rdata_q)) for loads, 0 for stores;
//   - always go to IDLE; request inputs in this cycle are ignored;
//   - a request dropped during ACCESS does not abort the access: the store is already committed and the load still completes.
// - Back-to-back: request held 4 cycles = two accesses; IDLE re-samples on the cycle after ACCESS.
// - Load/store latency: request edge +1 cycle; exactly one mem_ready pulse per access.
// - mem_read and mem_write both high in IDLE: the store is performed, no load data is returned (load_data=0), mem_err=1 in ACCESS.
// - Store lanes:
//   - byte: be = 4'b0001 << addr[1:0], wdata[7:0] replicated to all lanes;
//   - half: be = addr[1] ? 4'b1100 : 4'b0011, wdata[15:0] replicated;
//   - word: be = 4'b1111.
// - Load lanes:
//   - byte: rdata_q[8*addr[1:0] +: 8];
//   - half: rdata_q[16*addr[1] +: 16];
//   - extend to 32 bits by lu (0 = sign, 1 = zero); lu is ignored for word.
// - Address wrap: the word index is taken modulo 2**ADDR_W; out-of-range addresses alias silently.
// - Reset asserted mid-access: the FSM returns to IDLE immediately; a store already clocked remains in memory.
// CONFIGURATION
// - Macro: DMEM_MISALIGN_TRAP_EN.
// - Defined: an access is misaligned if it is a half with addr[0]=1, or a word with addr[1:0]!=0.
//   - A misaligned store does not write the SRAM.
//   - A misaligned load returns load_data=0.
//   - mem_err=1 in the ACCESS cycle; mem_ready timing is unchanged.
// - Undefined: low address bits are masked (half ignores addr[0]; word ignores addr[1:0]) and the access proceeds; mem_err is raised only for simultaneous read+write.
// STRUCTURE
// - dmem_pkg:
//   - typedef enum logic[1:0] lst_e {LST_B=2'b00, LST_H=2'b01, LST_W=2'b11};
//   - typedef enum logic state_e {IDLE, ACCESS};
//   - function be_gen(lst, a[1:0]) returns logic[3:0];
//   - function ld_extend(word, lst, lu, a[1:0]) returns logic[31:0].
// - Sub-module dmem_sram: 2**ADDR_W x 32, 4 byte enables, single port, synchronous write, registered read.
// - The top level holds the FSM, latches, lane steering and error logic.
// TESTING
// - After reset, check outputs are 0. Then sw 0xDEADBEEF @0x10, then lw @0x10: mem_ready on the 2nd cycle of each access; lw returns load_data=0xDEADBEEF.
// - With word 0x80FF7F01 @0x20:
//   - lb @0x23 -> 0xFFFFFF80;
//   - lbu @0x23 -> 0x00000080;
//   - lh @0x22 -> 0xFFFF80FF;
//   - lhu @0x20 -> 0x00007F01.
// - sb 0xAB @0x31 onto 0x00000000, then sh 0x1234 @0x32; lw @0x30 -> 0x1234AB00.
// - mem_read held 4 cycles (two back-to-back loads, @0x10 then @0x20): exactly 2 mem_ready pulses, in cycles 2 and 4.
// - Misalignment, lw @0x11 and sw @0x12 (pre-load 0x55555555 @0x10, then read back @0x10):
//   - with DMEM_MISALIGN_TRAP_EN: mem_err=1 and load_data=0; the read-back @0x10 returns 0x55555555;
//   - without: lw returns the word @0x10; the sw writes @0x10.
// - rstn pulsed low during ACCESS: mem_ready drops asynchronously and the FSM is in IDLE; a store issued before the reset reads back correctly.
// - mem_read and mem_write both high: the store is performed, mem_err=1, load_data=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// Lane enables, store replication, load extension and alignment rules.
package dmem_pkg;

    typedef enum logic [1:0] {
        LST_B = 2'b00,
        LST_H = 2'b01,
        LST_W = 2'b11
    } lst_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_e;

    // Reserved size 2'b10 falls through to word everywhere.
    function automatic logic [3:0] be_gen(
        input logic [1:0] lst,
        input logic [1:0] a
    );
        case (lst)
            LST_B:   be_gen = 4'b0001 << a;
            LST_H:   be_gen = a[1] ? 4'b1100 : 4'b0011;
            default: be_gen = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wd_steer(
        input logic [1:0]  lst,
        input logic [31:0] w
    );
        case (lst)
            LST_B:   wd_steer = {4{w[7:0]}};
            LST_H:   wd_steer = {2{w[15:0]}};
            default: wd_steer = w;
        endcase
    endfunction

    function automatic logic [31:0] ld_extend(
        input logic [31:0] word,
        input logic [1:0]  lst,
        input logic        lu,
        input logic [1:0]  a
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{a, 3'b000} +: 8];
        h = word[{a[1], 4'b0000} +: 16];
        case (lst)
            LST_B:   ld_extend = {{24{~lu & b[7]}}, b};
            LST_H:   ld_extend = {{16{~lu & h[15]}}, h};
            default: ld_extend = word;
        endcase
    endfunction

    function automatic logic misaligned(
        input logic [1:0] lst,
        input logic [1:0] a
    );
        case (lst)
            LST_B:   misaligned = 1'b0;
            LST_H:   misaligned = a[0];
            default: misaligned = (a != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/dmem_sram.sv
// Single-port 2**ADDR_W x 32 SRAM, byte-enabled synchronous write,
// registered read. Ports: clk, rstn, we, be, re, idx, wdata, rdata.
module dmem_sram #(
    parameter int ADDR_W = 10,
    parameter int INIT_Z = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic              re,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Contents are not reset; optional zero fill happens at elaboration.
    logic [31:0] mem [DEPTH] =
        '{default: (INIT_Z != 0) ? 32'h0 : 32'hx};

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Two-cycle data-memory responder: IDLE samples the request and hits the
// SRAM, ACCESS returns mem_ready with extended load data and error flag.
// Ports: clk, rstn, mem_read, mem_write, lst, lu, addr, wdata (in);
//        load_data, mem_ready, mem_err (out).
// Macro DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses
// instead of masking the low address bits.
import dmem_pkg::*;

module dmem_responder #(
    parameter int ADDR_W = 10,
    parameter int INIT_Z = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  lst,
    input  logic        lu,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        mem_ready,
    output logic        mem_err
);

    state_e      state;
    state_e      state_nx;
    logic [1:0]  a_q;
    logic [1:0]  lst_q;
    logic        lu_q;
    logic        rd_q;
    logic        wr_q;
    logic        mis_q;
    logic        req;
    logic        take;
    logic        mis_now;
    logic        we;
    logic        re;
    logic [31:0] rdata_q;
    logic        unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    assign req  = mem_read | mem_write;
    assign take = (state == IDLE) & req;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign mis_now = misaligned(lst, addr[1:0]);
`else
    assign mis_now = 1'b0;
`endif

    // A combined read+write is treated as a store only.
    assign we = take & mem_write & ~mis_now;
    assign re = take & mem_read & ~mem_write;

    dmem_sram #(
        .ADDR_W (ADDR_W),
        .INIT_Z (INIT_Z)
    ) u_sram (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we),
        .be    (be_gen(lst, addr[1:0])),
        .re    (re),
        .idx   (addr[ADDR_W+1:2]),
        .wdata (wd_steer(lst, wdata)),
        .rdata (rdata_q)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q   <= '0;
            lst_q <= '0;
            lu_q  <= 1'b0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            mis_q <= 1'b0;
        end else if (take) begin
            a_q   <= addr[1:0];
            lst_q <= lst;
            lu_q  <= lu;
            rd_q  <= mem_read;
            wr_q  <= mem_write;
            mis_q <= mis_now;
        end
    end

    always_comb begin
        state_nx  = state;
        mem_ready = 1'b0;
        mem_err   = 1'b0;
        load_data = '0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                state_nx  = IDLE;
                mem_ready = 1'b1;
                mem_err   = (rd_q & wr_q) | mis_q;
                if (rd_q & ~wr_q & ~mis_q) begin
                    load_data = ld_extend(rdata_q, lst_q, lu_q, a_q);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
